// File: rtl/tb_result_checker.sv
// tb_result_checker: snoops CPU writes to a test port and checks them against a runtime-loaded golden table
module tb_result_checker #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int DEPTH = 256,
  parameter int IW = 8,
  parameter int EW = 8,
  parameter int CW = 16,
  parameter logic [AW-1:0] TEST_PORT = 30'h40,
  parameter logic [DW-1:0] BEGIN_SYM = 32'h00000932,
  parameter logic [DW-1:0] END_SYM = 32'h00000D5D,
  parameter logic [CW-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  input  logic          cpu_wen,
  input  logic          ld_en,
  input  logic [IW-1:0] ld_idx,
  input  logic [DW-1:0] ld_data,
  input  logic [IW:0]   cfg_num,
  output logic          finish,
  output logic          pass,
  output logic          timeout,
  output logic [EW-1:0] error_num,
  output logic [CW-1:0] duration,
  output logic [IW:0]   chk_cnt,
  output logic [IW-1:0] first_err_idx,
  output logic [DW-1:0] first_err_data
);
  localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, REPORT = 2'd2;
  localparam int SW = EW + IW + 2;
  localparam logic [EW-1:0] EMAX = {{(EW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [DW-1:0] table_q [DEPTH];
  logic [1:0] state_q, state_d;
  logic armed_q, to_q, to_d;
  logic [EW-1:0] err_q, err_d;
  logic [CW-1:0] dur_q, dur_d;
  logic [IW:0] cnt_q, cnt_d, cfg_q, cfg_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic [DW-1:0] fdata_q, fdata_d;
  logic accept, done, mis;
  // all-ones is reserved for the idle marker, so counting stops one short
  function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] a, input logic [IW:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return s > SW'(EMAX) ? EMAX : s[EW-1:0];
  endfunction
  assign accept = cpu_wen && cpu_addr == TEST_PORT && armed_q;
  assign done = cnt_q == cfg_q;
  assign mis = cpu_data != table_q[cnt_q[IW-1:0]];
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    dur_d = dur_q;
    cnt_d = cnt_q;
    cfg_d = cfg_q;
    fidx_d = fidx_q;
    fdata_d = fdata_q;
    to_d = to_q;
    if (state_q == IDLE) begin
      if (accept && cpu_data == BEGIN_SYM) begin
        state_d = CHECK;
        err_d = '0;
        cfg_d = cfg_num;
      end
    end else if (state_q == CHECK) begin
      dur_d = dur_q == '1 ? dur_q : dur_q + CW'(1);
      if (done) begin
        state_d = REPORT;
      end else if (accept && cpu_data == END_SYM) begin
        err_d = sat_add(err_q, cfg_q - cnt_q);
        state_d = REPORT;
      end else begin
        if (accept) begin
          cnt_d = cnt_q + (IW+1)'(1);
          err_d = mis ? sat_add(err_q, (IW+1)'(1)) : err_q;
          fidx_d = mis && err_q == '0 ? cnt_q[IW-1:0] : fidx_q;
          fdata_d = mis && err_q == '0 ? cpu_data : fdata_q;
        end
        if (dur_q == TO_LAST) begin
          to_d = 1'b1;
          state_d = REPORT;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      err_q <= '1;
      dur_q <= '0;
      cnt_q <= '0;
      cfg_q <= '0;
      fidx_q <= '0;
      fdata_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= accept ? 1'b0 : (!cpu_wen ? 1'b1 : armed_q);
      err_q <= err_d;
      dur_q <= dur_d;
      cnt_q <= cnt_d;
      cfg_q <= cfg_d;
      fidx_q <= fidx_d;
      fdata_q <= fdata_d;
      to_q <= to_d;
    end
  end
  // golden table survives reset so one load serves repeated runs
  always_ff @(posedge clk) begin
    if (state_q == IDLE && ld_en) table_q[ld_idx] <= ld_data;
  end
  assign finish = state_q == REPORT;
  assign pass = finish && err_q == '0 && !to_q;
  assign timeout = to_q;
  assign error_num = err_q;
  assign duration = dur_q;
  assign chk_cnt = cnt_q;
  assign first_err_idx = fidx_q;
  assign first_err_data = fdata_q;
endmodule

// File: tb/tb_tb_result_checker.sv
// tb_tb_result_checker: directed scenario bench for tb_result_checker
module tb_tb_result_checker;
  localparam logic [29:0] PORT = 30'h40;
  localparam logic [31:0] BSYM = 32'h00000932;
  localparam logic [31:0] ESYM = 32'h00000D5D;
  logic clk = 0, rst = 0;
  logic [29:0] cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic cpu_wen = 0, ld_en = 0;
  logic [7:0] ld_idx = '0;
  logic [31:0] ld_data = '0;
  logic [8:0] cfg_num = 9'd4;
  logic finish, pass, timeout;
  logic [7:0] error_num, first_err_idx;
  logic [15:0] duration;
  logic [8:0] chk_cnt;
  logic [31:0] first_err_data;
  int checks = 0, errors = 0;

  tb_result_checker #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wen(cpu_wen),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .cfg_num(cfg_num),
    .finish(finish), .pass(pass), .timeout(timeout), .error_num(error_num),
    .duration(duration), .chk_cnt(chk_cnt), .first_err_idx(first_err_idx),
    .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk) rst = 0;
    @(negedge clk) rst = 1;
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk) begin ld_en = 1; ld_idx = idx; ld_data = d; end
    @(negedge clk) ld_en = 0;
  endtask

  task automatic load_std();
    load(8'd0, 32'd0); load(8'd1, 32'd1); load(8'd2, 32'd1); load(8'd3, 32'd2);
  endtask

  task automatic port_write(input logic [31:0] d, input int hold);
    @(negedge clk) begin cpu_wen = 1; cpu_addr = PORT; cpu_data = d; end
    repeat (hold - 1) @(negedge clk);
    @(negedge clk) cpu_wen = 0;
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 60 && !finish; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (error_num !== 8'hFF) begin errors++; $display("FAIL reset_err got %h exp ff", error_num); end
    checks++; if ({finish, pass, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {finish, pass, timeout}); end
    checks++; if ({duration, chk_cnt, first_err_idx} !== '0 || first_err_data !== '0) begin errors++; $display("FAIL reset_cnt got %h %h %h %h exp 0", duration, chk_cnt, first_err_idx, first_err_data); end
    rst = 1;
  endtask

  task automatic test_pass();
    do_reset(); load_std();
    port_write(BSYM, 1);
    checks++; if (error_num !== 8'h00) begin errors++; $display("FAIL arm_err got %h exp 00", error_num); end
    port_write(32'd0, 1); port_write(32'd1, 1); port_write(32'd1, 1); port_write(32'd2, 1);
    wait_finish();
    checks++; if ({finish, pass, timeout} !== 3'b110) begin errors++; $display("FAIL pass_flags got %b exp 110", {finish, pass, timeout}); end
    checks++; if (error_num !== 8'h00 || chk_cnt !== 9'd4) begin errors++; $display("FAIL pass_cnt got %h %0d exp 00 4", error_num, chk_cnt); end
    checks++; if (duration !== 16'd9) begin errors++; $display("FAIL pass_dur got %0d exp 9", duration); end
  endtask

  task automatic test_mismatch();
    do_reset();
    port_write(BSYM, 1);
    port_write(32'd0, 1); port_write(32'd1, 1); port_write(32'd5, 1);
    checks++; if (error_num !== 8'd1) begin errors++; $display("FAIL mis_latency got %h exp 01", error_num); end
    port_write(32'd2, 1);
    wait_finish();
    checks++; if ({finish, pass} !== 2'b10 || error_num !== 8'd1) begin errors++; $display("FAIL mis_flags got %b %h exp 10 01", {finish, pass}, error_num); end
    checks++; if (first_err_idx !== 8'd2 || first_err_data !== 32'd5) begin errors++; $display("FAIL mis_first got %h %h exp 02 5", first_err_idx, first_err_data); end
  endtask

  task automatic test_stall();
    do_reset();
    port_write(BSYM, 1);
    port_write(32'd0, 3);
    checks++; if (chk_cnt !== 9'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", chk_cnt); end
    port_write(32'd1, 1); port_write(32'd1, 3); port_write(32'd2, 1);
    wait_finish();
    checks++; if (chk_cnt !== 9'd4 || pass !== 1'b1) begin errors++; $display("FAIL stall_final got %0d %b exp 4 1", chk_cnt, pass); end
  endtask

  task automatic test_end();
    do_reset();
    port_write(BSYM, 1); port_write(32'd0, 1); port_write(32'd1, 1); port_write(ESYM, 1);
    @(negedge clk);
    checks++; if (finish !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL end_flags got %b %b exp 1 0", finish, pass); end
    checks++; if (error_num !== 8'd2 || chk_cnt !== 9'd2) begin errors++; $display("FAIL end_cnt got %h %0d exp 02 2", error_num, chk_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    port_write(BSYM, 1);
    wait_finish();
    checks++; if ({finish, pass, timeout} !== 3'b101) begin errors++; $display("FAIL to_flags got %b exp 101", {finish, pass, timeout}); end
    checks++; if (duration !== 16'd20 || chk_cnt !== 9'd0) begin errors++; $display("FAIL to_dur got %0d %0d exp 20 0", duration, chk_cnt); end
    port_write(32'd0, 1);
    checks++; if (chk_cnt !== 9'd0 || duration !== 16'd20) begin errors++; $display("FAIL report_frozen got %0d %0d exp 0 20", chk_cnt, duration); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    port_write(BSYM, 1); port_write(32'd0, 1);
    #2 rst = 0;
    #1;
    checks++; if (error_num !== 8'hFF || chk_cnt !== 9'd0 || finish !== 1'b0) begin errors++; $display("FAIL midrst got %h %0d %b exp ff 0 0", error_num, chk_cnt, finish); end
    @(negedge clk) rst = 1;
    load_std();
    port_write(32'h1234, 1);
    checks++; if (error_num !== 8'hFF) begin errors++; $display("FAIL idle_ignore got %h exp ff", error_num); end
    port_write(BSYM, 1);
    load(8'd0, 32'd99);
    port_write(32'd0, 1); port_write(32'd1, 1); port_write(32'd1, 1); port_write(32'd2, 1);
    wait_finish();
    checks++; if (pass !== 1'b1 || error_num !== 8'd0) begin errors++; $display("FAIL midrst_pass got %b %h exp 1 00", pass, error_num); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_stall();
    test_end();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
